// File: rtl/ddr_port_arbiter.sv
// Arbitrates one Spartan-6 MCB command port between a write (capture) and a read (readback) requester.
// Writes win until the streak limit; reads are only issued when the MCB read FIFO can absorb the burst.
module ddr_port_arbiter #(
  parameter int RD_FIFO_DEPTH = 64,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic        ddr_usrclk,
  input  logic        ddr_usrreset,
  input  logic        calib_done,
  input  logic        wr_req,
  input  logic [29:0] wr_addr,
  input  logic [5:0]  wr_bl,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [29:0] rd_addr,
  input  logic [5:0]  rd_bl,
  output logic        rd_ack,
  input  logic        rd_pop,
  output logic        mcb_cmd_en,
  output logic [2:0]  mcb_cmd_instr,
  output logic [5:0]  mcb_cmd_bl,
  output logic [29:0] mcb_cmd_byte_addr,
  input  logic        mcb_cmd_full,
  output logic [6:0]  rd_outstanding,
  output logic        busy,
  output logic        arb_error
);

  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE, GAP} state_t;

  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  state_t        state, state_nxt;
  logic [SW-1:0] wr_streak;
  logic          grant_wr, grant_rd;
  logic          wr_ok, rd_ok, streak_ok;
  logic [7:0]    rd_need;
  logic [6:0]    cnt_add, cnt_next;
  logic          pop_err;

  // Eligibility sum is widened so a full FIFO plus a 64-word burst cannot wrap.
  assign rd_need   = {1'b0, rd_outstanding} + {2'b00, rd_bl} + 8'd1;
  assign wr_ok     = wr_req;
  assign rd_ok     = rd_req && (rd_need <= 8'(RD_FIFO_DEPTH));
  assign streak_ok = wr_streak < SW'(MAX_WR_STREAK);

  always_ff @(posedge ddr_usrclk) begin
    if (ddr_usrreset) state <= WAIT_CAL;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      WAIT_CAL: if (calib_done) state_nxt = IDLE;
      IDLE: begin
        if (!calib_done) begin
          state_nxt = WAIT_CAL;
        end else if (!mcb_cmd_full) begin
          if (wr_ok && (!rd_ok || streak_ok)) grant_wr = 1'b1;
          else if (rd_ok)                     grant_rd = 1'b1;
          if (grant_wr || grant_rd) state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = WAIT_CAL;
    endcase
  end

  // A pop on an empty count is a requester bug: flag it and leave the count alone.
  assign pop_err  = rd_pop && (rd_outstanding == 7'd0);
  assign cnt_add  = (state == ISSUE && mcb_cmd_instr == INSTR_RD) ? ({1'b0, mcb_cmd_bl} + 7'd1) : 7'd0;
  assign cnt_next = rd_outstanding + cnt_add - {6'd0, (rd_pop && !pop_err)};

  always_ff @(posedge ddr_usrclk) begin
    if (ddr_usrreset) begin
      mcb_cmd_en        <= 1'b0;
      mcb_cmd_instr     <= 3'b000;
      mcb_cmd_bl        <= 6'd0;
      mcb_cmd_byte_addr <= 30'd0;
      wr_ack            <= 1'b0;
      rd_ack            <= 1'b0;
      busy              <= 1'b0;
      arb_error         <= 1'b0;
      rd_outstanding    <= 7'd0;
      wr_streak         <= '0;
    end else begin
      mcb_cmd_en     <= grant_wr || grant_rd;
      wr_ack         <= grant_wr;
      rd_ack         <= grant_rd;
      busy           <= (state_nxt != IDLE);
      rd_outstanding <= cnt_next;
      if (pop_err) arb_error <= 1'b1;
      if (grant_wr) begin
        mcb_cmd_instr     <= INSTR_WR;
        mcb_cmd_bl        <= wr_bl;
        mcb_cmd_byte_addr <= {wr_addr[29:2], 2'b00};
        if (wr_addr[1:0] != 2'b00) arb_error <= 1'b1;
        if (streak_ok) wr_streak <= wr_streak + 1'b1;
      end else if (grant_rd) begin
        mcb_cmd_instr     <= INSTR_RD;
        mcb_cmd_bl        <= rd_bl;
        mcb_cmd_byte_addr <= {rd_addr[29:2], 2'b00};
        if (rd_addr[1:0] != 2'b00) arb_error <= 1'b1;
        wr_streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: directed scenarios plus a randomized phase
// checked against a transaction-level model of the grant and FIFO-credit rules.
module tb_ddr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, calib_done;
  logic        wr_req, rd_req, wr_ack, rd_ack, rd_pop;
  logic [29:0] wr_addr, rd_addr, mcb_cmd_byte_addr;
  logic [5:0]  wr_bl, rd_bl, mcb_cmd_bl;
  logic        mcb_cmd_en, mcb_cmd_full, busy, arb_error;
  logic [2:0]  mcb_cmd_instr;
  logic [6:0]  rd_outstanding;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.RD_FIFO_DEPTH(64), .MAX_WR_STREAK(4)) dut (
    .ddr_usrclk(clk), .ddr_usrreset(rst), .calib_done(calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_bl(wr_bl), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_bl(rd_bl), .rd_ack(rd_ack),
    .rd_pop(rd_pop), .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr),
    .mcb_cmd_bl(mcb_cmd_bl), .mcb_cmd_byte_addr(mcb_cmd_byte_addr),
    .mcb_cmd_full(mcb_cmd_full), .rd_outstanding(rd_outstanding),
    .busy(busy), .arb_error(arb_error)
  );

  typedef struct {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  cmd_t exp_q[$];
  int   nchecks = 0;
  int   nfails  = 0;
  int   cyc     = 0;
  int   last_en = -1;
  bit   chk_gap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input bit is_rd, input logic [5:0] bl, input logic [29:0] addr);
    cmd_t c;
    c.instr = is_rd ? 3'b001 : 3'b000;
    c.bl    = bl;
    c.addr  = {addr[29:2], 2'b00};
    exp_q.push_back(c);
  endtask

  // Monitor: every command the DUT presents is matched against the oldest expectation.
  always @(negedge clk) begin
    cmd_t e;
    cyc++;
    if (!chk_gap) last_en = -1;
    if (mcb_cmd_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        nchecks++; nfails++;
        $display("FAIL unexpected_cmd: instr %0d bl %0d addr 0x%0h with no expectation",
                 mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr);
      end else begin
        e = exp_q.pop_front();
        check("cmd_instr", 32'(mcb_cmd_instr), 32'(e.instr));
        check("cmd_bl",    32'(mcb_cmd_bl),    32'(e.bl));
        check("cmd_addr",  32'(mcb_cmd_byte_addr), 32'(e.addr));
        check("wr_ack_with_cmd", 32'(wr_ack), 32'(e.instr == 3'b000));
        check("rd_ack_with_cmd", 32'(rd_ack), 32'(e.instr == 3'b001));
      end
      if (chk_gap && last_en >= 0) check("cmd_spacing", 32'(cyc - last_en), 32'd3);
      last_en = cyc;
    end else if (wr_ack === 1'b1 || rd_ack === 1'b1) begin
      nchecks++; nfails++;
      $display("FAIL ack_without_cmd: wr_ack %0b rd_ack %0b", wr_ack, rd_ack);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for either ack; leaves the caller on the negedge of the ISSUE cycle.
  task automatic wait_ack(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_ack || rd_ack) && n < budget);
    if (!(wr_ack || rd_ack)) begin
      nchecks++; nfails++;
      $display("FAIL %s: no ack within %0d cycles", name, budget);
    end
  endtask

  task automatic count_en(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (mcb_cmd_en) n++;
    end
  endtask

  initial begin
    int n;
    int m_cnt, m_streak;
    bit m_err;
    rst = 1'b1; calib_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_pop = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_bl = '0; rd_bl = '0; mcb_cmd_full = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_en", 32'(mcb_cmd_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(rd_outstanding), 0);
    check("rst_err", 32'(arb_error), 0);
    check("rst_addr", 32'(mcb_cmd_byte_addr), 0);

    // Calibration gating, then first-command latency
    rst = 1'b0; wr_req = 1'b1; wr_addr = 30'h100; wr_bl = 6'd3;
    count_en(10, n);
    check("nocal_no_cmd", 32'(n), 0);
    check("nocal_busy", 32'(busy), 1);
    expect_cmd(1'b0, 6'd3, 30'h100);
    calib_done = 1'b1;
    @(negedge clk);
    check("cal_en_not_early", 32'(mcb_cmd_en), 0);
    @(negedge clk);
    check("cal_en_lat2", 32'(mcb_cmd_en), 1);
    check("cal_wr_ack_lat2", 32'(wr_ack), 1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);

    // Write streak with both sides continuously requesting
    do_reset();
    wr_bl = 6'd15; rd_bl = 6'd15; wr_addr = 30'h1000; rd_addr = 30'h2000;
    for (int i = 0; i < 10; i++) expect_cmd(i % 5 == 4, 6'd15, (i % 5 == 4) ? 30'h2000 : 30'h1000);
    chk_gap = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 10; i++) begin
      @(negedge clk);
      if (mcb_cmd_en) n++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("streak_cmd_count", 32'(n), 10);
    chk_gap = 1'b0;
    @(negedge clk);
    check("streak_cnt", 32'(rd_outstanding), 32);

    // Read FIFO credit: full FIFO blocks a one-word read until a pop
    do_reset();
    rd_bl = 6'd63; rd_addr = 30'h3000;
    expect_cmd(1'b1, 6'd63, 30'h3000);
    rd_req = 1'b1;
    wait_ack("big_read", 20);
    rd_req = 1'b0;
    @(negedge clk);
    check("cnt_full", 32'(rd_outstanding), 64);
    rd_bl = 6'd0; rd_addr = 30'h3100; rd_req = 1'b1;
    count_en(6, n);
    check("held_no_cmd", 32'(n), 0);
    expect_cmd(1'b1, 6'd0, 30'h3100);
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
    check("cnt_after_pop", 32'(rd_outstanding), 63);
    wait_ack("small_read", 10);
    rd_req = 1'b0;
    @(negedge clk);
    check("cnt_refill", 32'(rd_outstanding), 64);

    // Issue and pop in the same cycle
    do_reset();
    rd_bl = 6'd9; rd_addr = 30'h4000;
    expect_cmd(1'b1, 6'd9, 30'h4000);
    rd_req = 1'b1;
    wait_ack("read10", 20);
    rd_req = 1'b0;
    @(negedge clk);
    check("cnt_10", 32'(rd_outstanding), 10);
    rd_bl = 6'd7; rd_addr = 30'h4100;
    expect_cmd(1'b1, 6'd7, 30'h4100);
    rd_req = 1'b1;
    wait_ack("read_pop", 20);
    rd_req = 1'b0; rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
    check("cnt_issue_pop", 32'(rd_outstanding), 17);

    // Misaligned address and underflow pop
    do_reset();
    check("err_clear", 32'(arb_error), 0);
    wr_addr = 30'h103; wr_bl = 6'd0;
    expect_cmd(1'b0, 6'd0, 30'h100);
    wr_req = 1'b1;
    wait_ack("misaligned", 20);
    wr_req = 1'b0;
    @(negedge clk);
    check("misaligned_addr", 32'(mcb_cmd_byte_addr), 32'h100);
    repeat (5) @(negedge clk);
    check("misaligned_err_sticky", 32'(arb_error), 1);
    do_reset();
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
    @(negedge clk);
    check("underflow_err", 32'(arb_error), 1);
    check("underflow_cnt", 32'(rd_outstanding), 0);

    // Command FIFO full, then reset during ISSUE
    do_reset();
    mcb_cmd_full = 1'b1;
    wr_addr = 30'h200; wr_bl = 6'd2; rd_addr = 30'h300; rd_bl = 6'd1;
    wr_req = 1'b1; rd_req = 1'b1;
    count_en(8, n);
    check("full_no_cmd", 32'(n), 0);
    expect_cmd(1'b0, 6'd2, 30'h200);
    mcb_cmd_full = 1'b0;
    wait_ack("after_full", 10);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    wr_addr = 30'h5554; wr_bl = 6'd33;
    expect_cmd(1'b0, 6'd33, 30'h5554);
    wr_req = 1'b1;
    wait_ack("pre_reset", 10);
    rst = 1'b1; wr_req = 1'b0; calib_done = 1'b0;
    @(negedge clk);
    check("midrst_en", 32'(mcb_cmd_en), 0);
    check("midrst_ack", 32'({wr_ack, rd_ack}), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cmd", 32'({mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr}), 0);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("midrst_waitcal_busy", 32'(busy), 1);

    // Randomized phase against a transaction-level model
    calib_done = 1'b1;
    do_reset();
    m_cnt = 0; m_streak = 0; m_err = 1'b0;
    for (int it = 0; it < 300; it++) begin
      int kind, npop;
      bit fit, wr_el, rd_el, win_rd;
      logic [5:0]  rb, wb;
      logic [29:0] ra, wa;
      kind = $urandom_range(0, 2);
      wb = 6'($urandom_range(0, 63)); rb = 6'($urandom_range(0, 63));
      wa = 30'($urandom); ra = 30'($urandom);
      if ($urandom_range(0, 7) != 0) begin wa[1:0] = 2'b00; ra[1:0] = 2'b00; end
      npop = $urandom_range(0, 4);
      if (npop > m_cnt) npop = m_cnt;
      while (kind == 1 && m_cnt + rb + 1 - npop > 64) npop++;
      for (int j = 0; j < npop; j++) begin
        rd_pop = 1'b1;
        @(negedge clk);
      end
      rd_pop = 1'b0;
      m_cnt -= npop;
      fit   = (m_cnt + rb + 1 <= 64);
      wr_el = (kind != 1);
      rd_el = (kind != 0) && fit;
      win_rd = !(wr_el && (!rd_el || m_streak < 4));
      if (win_rd) begin
        m_streak = 0;
        m_cnt += rb + 1;
        if (ra[1:0] != 2'b00) m_err = 1'b1;
        expect_cmd(1'b1, rb, ra);
      end else begin
        if (m_streak < 4) m_streak++;
        if (wa[1:0] != 2'b00) m_err = 1'b1;
        expect_cmd(1'b0, wb, wa);
      end
      wr_addr = wa; wr_bl = wb; rd_addr = ra; rd_bl = rb;
      wr_req = (kind != 1); rd_req = (kind != 0);
      wait_ack("rand_ack", 20);
      wr_req = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      check("rand_cnt", 32'(rd_outstanding), 32'(m_cnt));
    end
    check("rand_err", 32'(arb_error), 32'(m_err));
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Shares one Spartan-6 MCB command port between the ADC capture writer and the USB readback reader. Accepts one burst request at a time from each side and picks a winner per command, with writes favoured and reads guaranteed progress. Issues the MCB command and tracks read words still owed to the MCB read FIFO, so a read is never issued that could overflow it. Sits between the capture/readback sequencers and `ddr_interface`, in the `ddr_usrclk` domain.

## Interface
- RD_FIFO_DEPTH, 64: MCB read-data FIFO depth in 32-bit words.
- MAX_WR_STREAK, 4: consecutive write grants allowed while a read is eligible.
- `ddr_usrclk` in 1: MCB user clock; the only clock.
- `ddr_usrreset` in 1: synchronous, active-high reset.
- `calib_done` in 1: MCB calibration complete.
- `wr_req` in 1: write burst request; held level until `wr_ack`.
- `wr_addr` in 30: write byte address.
- `wr_bl` in 6: write burst length minus 1.
- `wr_ack` out 1: one-cycle pulse when the write command is issued.
- `rd_req`, `rd_addr`, `rd_bl`, `rd_ack`: same as the write set, for reads.
- `rd_pop` in 1: one word popped from the MCB read FIFO (`rd_en & ~rd_empty`).
- `mcb_cmd_en` out 1: MCB command enable.
- `mcb_cmd_instr` out 3: 3'b000 write, 3'b001 read.
- `mcb_cmd_bl` out 6: MCB command burst length.
- `mcb_cmd_byte_addr` out 30: MCB command byte address.
- `mcb_cmd_full` in 1: MCB command FIFO full.
- `rd_outstanding` out 7: read words issued but not yet popped.
- `busy` out 1: high in any state except IDLE.
- `arb_error` out 1: sticky error flag; cleared only by reset.

## Operation
- States and transitions:
  - WAIT_CAL → IDLE when `calib_done`=1.
  - IDLE → WAIT_CAL when `calib_done`=0.
  - IDLE → ISSUE when a grant is made.
  - ISSUE → GAP unconditionally.
  - GAP → IDLE unconditionally.
- Grant decision, made in IDLE only, and only when `calib_done`=1 and `mcb_cmd_full`=0:
  - Write is eligible when `wr_req`=1.
  - Read is eligible when `rd_req`=1 and `rd_outstanding + rd_bl + 1 <= RD_FIFO_DEPTH`. Evaluate this sum at 8 bits.
  - Both eligible: grant write if `wr_streak < MAX_WR_STREAK`, otherwise grant read.
  - Only one eligible: grant it.
  - Neither eligible: stay in IDLE.
- `wr_streak` (internal counter):
  - Increments, saturating at MAX_WR_STREAK, on each write grant.
  - Clears on each read grant and on reset.
- On grant, latch the instr, bl and address of the winner into the `mcb_cmd_*` registers.
  - Address bits [1:0] are forced to 00.
  - If the requested address had nonzero bits [1:0], set `arb_error`.
- ISSUE: `mcb_cmd_en`=1 and the matching ack =1, both for exactly this cycle.
- GAP: requests are not sampled. This gives the requester one cycle to drop its req after the ack.
- `rd_outstanding` update each cycle:
  - Add bl+1 if a read is in ISSUE.
  - Subtract 1 if `rd_pop`=1.
  - Both in the same cycle: net change is bl.
  - `rd_pop` while the count is 0: set `arb_error` and hold the count at 0.
- `calib_done` falling:
  - In ISSUE or GAP: finish the command, then go to WAIT_CAL from IDLE.
  - `rd_outstanding` is kept.
- Reset (including mid-command): next edge gives state WAIT_CAL, all outputs 0, `mcb_cmd_*` 0, `rd_outstanding` 0, `wr_streak` 0, `arb_error` 0.

## Timing
- All outputs are registered.
- Latency: a request seen in IDLE at edge N produces `mcb_cmd_en` and the ack during cycle N+1.
- IDLE is re-entered at N+3. Peak rate is one command per 3 cycles.
- `mcb_cmd_instr`, `mcb_cmd_bl` and `mcb_cmd_byte_addr` stay stable from ISSUE until the next grant.
- `mcb_cmd_full` is checked only at the decision edge. Only this block writes the MCB command FIFO, so it cannot fill between decision and issue.
- Pops between decision and issue only lower `rd_outstanding`, so read eligibility stays safe.
- The requester must deassert req in the cycle after the ack. A req still high in IDLE after GAP is treated as a new request.

## Test plan
- Reset, then `calib_done` low for 10 cycles with `wr_req`=1 → no `mcb_cmd_en`, `busy`=1. Raise `calib_done` → `mcb_cmd_en` 2 cycles later with instr 000, `wr_ack` in the same cycle.
- Continuous `wr_req` and `rd_req`, `rd_outstanding`=0, bl=15 → grant order W,W,W,W,R,W,W,W,W,R. Commands spaced 3 cycles apart.
- Read, bl=63, with no pops → `rd_outstanding`=64. A second read, bl=0, is held until one `rd_pop`, then issues; count goes 63 → 64.
- Read issue with bl=7 in the same cycle as `rd_pop`, from a count of 10 → count 17.
- `wr_addr`=0x0000_0103 → `mcb_cmd_byte_addr`=0x0000_0100 and `arb_error` stays 1. `rd_pop` at count 0 → `arb_error`=1, count stays 0.
- `mcb_cmd_full`=1 with both reqs held → no issue. Release full → issue. Assert reset during ISSUE → next cycle all outputs 0, state WAIT_CAL.
